// File: rtl/control_unit_pkg.sv
// Shared constants for the control sequencer: opcodes, field encodings,
// sequencer states, decode groups and the branch-condition evaluator.
package control_unit_pkg;

  // Opcodes live in IR[31:24]
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_ADD   = 8'h01;
  localparam logic [7:0] OP_ADDS  = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_SUBS  = 8'h04;
  localparam logic [7:0] OP_AND   = 8'h05;
  localparam logic [7:0] OP_ORR   = 8'h06;
  localparam logic [7:0] OP_EOR   = 8'h07;
  localparam logic [7:0] OP_ADDI  = 8'h10;
  localparam logic [7:0] OP_SUBI  = 8'h11;
  localparam logic [7:0] OP_SUBIS = 8'h12;
  localparam logic [7:0] OP_LSL   = 8'h13;
  localparam logic [7:0] OP_LSR   = 8'h14;
  localparam logic [7:0] OP_MOVZ  = 8'h20;
  localparam logic [7:0] OP_LDUR  = 8'h30;
  localparam logic [7:0] OP_STUR  = 8'h31;
  localparam logic [7:0] OP_B     = 8'h40;
  localparam logic [7:0] OP_BR    = 8'h41;
  localparam logic [7:0] OP_CBZ   = 8'h42;
  localparam logic [7:0] OP_CBNZ  = 8'h43;
  localparam logic [7:0] OP_BCOND = 8'h44;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  // ALU function select
  localparam logic [4:0] FS_ADD    = 5'd0;
  localparam logic [4:0] FS_SUB    = 5'd1;
  localparam logic [4:0] FS_AND    = 5'd2;
  localparam logic [4:0] FS_ORR    = 5'd3;
  localparam logic [4:0] FS_EOR    = 5'd4;
  localparam logic [4:0] FS_LSL    = 5'd5;
  localparam logic [4:0] FS_LSR    = 5'd6;
  localparam logic [4:0] FS_PASS_A = 5'd7;
  localparam logic [4:0] FS_PASS_B = 5'd8;

  // PC select: hold, +4, relative (PC+K), absolute (PC_in)
  localparam logic [1:0] PS_HOLD = 2'b00;
  localparam logic [1:0] PS_INC  = 2'b01;
  localparam logic [1:0] PS_REL  = 2'b10;
  localparam logic [1:0] PS_ABS  = 2'b11;

  // Register-file write-data select
  localparam logic [1:0] DS_ALU = 2'b00;
  localparam logic [1:0] DS_PC  = 2'b01;
  localparam logic [1:0] DS_B   = 2'b10;
  localparam logic [1:0] DS_MEM = 2'b11;

  // B.cond condition codes (IR[3:0])
  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;

  // Bit positions inside SF = {V,C,N,Z}
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [2:0] {
    ST_FETCH, ST_EXEC, ST_MEM, ST_BRCHK, ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    GRP_NOP, GRP_ALU_R, GRP_ALU_I, GRP_MOVZ, GRP_LDUR, GRP_STUR,
    GRP_B, GRP_BR, GRP_CB, GRP_BCOND, GRP_HALT, GRP_ILL
  } grp_e;

  // Unknown condition codes are simply never taken
  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] sf);
    case (cond)
      COND_EQ: return sf[FLAG_Z];
      COND_NE: return !sf[FLAG_Z];
      COND_HS: return sf[FLAG_C];
      COND_LO: return !sf[FLAG_C];
      COND_GE: return !(sf[FLAG_N] ^ sf[FLAG_V]);
      COND_LT: return sf[FLAG_N] ^ sf[FLAG_V];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational instruction decode: opcode group, ALU controls,
// register fields and the sign/zero-extended immediates.
module control_unit_decode
  import control_unit_pkg::*;
#(
  parameter int K_WIDTH = 64
) (
  input  logic [31:0]        i_ir,
  output grp_e               o_grp,
  output logic [4:0]         o_fs,
  output logic               o_sl,
  output logic               o_c0,
  output logic               o_cbnz,
  output logic [4:0]         o_da,
  output logic [4:0]         o_sa,
  output logic [4:0]         o_sb,
  output logic [K_WIDTH-1:0] o_k_exec,
  output logic [K_WIDTH-1:0] o_k_br19
);

  logic [7:0]         w_op;
  logic [K_WIDTH-1:0] w_k_imm12;
  logic [K_WIDTH-1:0] w_k_imm16;
  logic [K_WIDTH-1:0] w_k_d9;
  logic [K_WIDTH-1:0] w_k_br26;

  assign w_op      = i_ir[31:24];
  assign w_k_imm12 = {{(K_WIDTH-12){1'b0}}, i_ir[21:10]};
  assign w_k_imm16 = {{(K_WIDTH-16){1'b0}}, i_ir[20:5]};
  assign w_k_d9    = {{(K_WIDTH-9){i_ir[20]}}, i_ir[20:12]};
  assign w_k_br26  = {{(K_WIDTH-26){i_ir[23]}}, i_ir[23:0], 2'b00};
  assign o_k_br19  = {{(K_WIDTH-21){i_ir[23]}}, i_ir[23:5], 2'b00};
  assign o_da      = i_ir[4:0];
  assign o_cbnz    = (w_op == OP_CBNZ);

  // Opcode -> group, ALU function, flag/carry strobes and the EXEC-cycle constant
  always_comb begin
    o_grp    = GRP_ILL;
    o_fs     = FS_ADD;
    o_sl     = 1'b0;
    o_c0     = 1'b0;
    o_k_exec = '0;
    o_sa     = i_ir[9:5];
    o_sb     = i_ir[20:16];
    case (w_op)
      OP_NOP:   o_grp = GRP_NOP;
      OP_ADD:   o_grp = GRP_ALU_R;
      OP_ADDS:  begin o_grp = GRP_ALU_R; o_sl = 1'b1; end
      OP_SUB:   begin o_grp = GRP_ALU_R; o_fs = FS_SUB; o_c0 = 1'b1; end
      OP_SUBS:  begin o_grp = GRP_ALU_R; o_fs = FS_SUB; o_c0 = 1'b1; o_sl = 1'b1; end
      OP_AND:   begin o_grp = GRP_ALU_R; o_fs = FS_AND; end
      OP_ORR:   begin o_grp = GRP_ALU_R; o_fs = FS_ORR; end
      OP_EOR:   begin o_grp = GRP_ALU_R; o_fs = FS_EOR; end
      OP_ADDI:  begin o_grp = GRP_ALU_I; o_k_exec = w_k_imm12; end
      OP_SUBI:  begin o_grp = GRP_ALU_I; o_k_exec = w_k_imm12; o_fs = FS_SUB; o_c0 = 1'b1; end
      OP_SUBIS: begin
        o_grp = GRP_ALU_I; o_k_exec = w_k_imm12; o_fs = FS_SUB; o_c0 = 1'b1; o_sl = 1'b1;
      end
      OP_LSL:   begin o_grp = GRP_ALU_I; o_k_exec = w_k_imm12; o_fs = FS_LSL; end
      OP_LSR:   begin o_grp = GRP_ALU_I; o_k_exec = w_k_imm12; o_fs = FS_LSR; end
      OP_MOVZ:  begin o_grp = GRP_MOVZ; o_k_exec = w_k_imm16; o_fs = FS_PASS_B; end
      OP_LDUR:  begin o_grp = GRP_LDUR; o_k_exec = w_k_d9; end
      // Stores read the data register through port B from the Rt field
      OP_STUR:  begin o_grp = GRP_STUR; o_k_exec = w_k_d9; o_sb = i_ir[4:0]; end
      OP_B:     begin o_grp = GRP_B; o_k_exec = w_k_br26; end
      OP_BR:    o_grp = GRP_BR;
      // The tested register passes through the ALU so Z reflects it in BRCHK
      OP_CBZ, OP_CBNZ: begin
        o_grp = GRP_CB; o_fs = FS_PASS_A; o_sl = 1'b1; o_sa = i_ir[4:0];
      end
      OP_BCOND: begin o_grp = GRP_BCOND; o_k_exec = o_k_br19; end
      OP_HALT:  o_grp = GRP_HALT;
      default:  o_grp = GRP_ILL;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/execute sequencer producing the datapath control word.
// Outputs are decoded from the state register and are forced low while
// reset is asserted so an aborted instruction cannot commit a write.
module control_unit
  import control_unit_pkg::*;
#(
  parameter int K_WIDTH      = 64,
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic [31:0]        i_ir,
  input  logic [3:0]         i_sf,
  output logic               o_as,
  output logic [1:0]         o_ds,
  output logic [1:0]         o_ps,
  output logic               o_pc_sel,
  output logic               o_k_sel,
  output logic               o_il,
  output logic               o_sl,
  output logic [4:0]         o_fs,
  output logic               o_c0,
  output logic               o_mw,
  output logic               o_rw,
  output logic [4:0]         o_da,
  output logic [4:0]         o_sa,
  output logic [4:0]         o_sb,
  output logic [K_WIDTH-1:0] o_k,
  output logic               o_halted,
  output logic               o_illegal,
  output logic               o_instr_done
);

  state_e             r_state;
  logic               r_illegal;
  grp_e               w_grp;
  logic [4:0]         w_fs, w_da, w_sa, w_sb;
  logic               w_sl, w_c0, w_cbnz;
  logic [K_WIDTH-1:0] w_k_exec, w_k_br19;

  control_unit_decode #(.K_WIDTH(K_WIDTH)) u_decode (
    .i_ir     (i_ir),
    .o_grp    (w_grp),
    .o_fs     (w_fs),
    .o_sl     (w_sl),
    .o_c0     (w_c0),
    .o_cbnz   (w_cbnz),
    .o_da     (w_da),
    .o_sa     (w_sa),
    .o_sb     (w_sb),
    .o_k_exec (w_k_exec),
    .o_k_br19 (w_k_br19)
  );

  assign o_illegal = r_illegal;

  // Sequencer state plus the sticky undefined-opcode flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: if (i_run) r_state <= ST_EXEC;
        ST_EXEC: begin
          case (w_grp)
            GRP_LDUR: r_state <= ST_MEM;
            GRP_CB:   r_state <= ST_BRCHK;
            GRP_HALT: r_state <= ST_HALT;
            GRP_ILL: begin
              r_illegal <= 1'b1;
              r_state   <= ILLEGAL_HALT ? ST_HALT : ST_FETCH;
            end
            default:  r_state <= ST_FETCH;
          endcase
        end
        ST_MEM, ST_BRCHK: r_state <= ST_FETCH;
        ST_HALT:          r_state <= ST_HALT;
        default:          r_state <= ST_FETCH;
      endcase
    end
  end

  // Control word from current state and decode; everything zero under reset
  always_comb begin
    o_as = 1'b0; o_ds = DS_ALU; o_ps = PS_HOLD; o_pc_sel = 1'b0; o_k_sel = 1'b0;
    o_il = 1'b0; o_sl = 1'b0; o_fs = FS_ADD; o_c0 = 1'b0; o_mw = 1'b0; o_rw = 1'b0;
    o_da = '0; o_sa = '0; o_sb = '0; o_k = '0; o_halted = 1'b0; o_instr_done = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        ST_FETCH: if (i_run) begin
          o_ds = DS_MEM; o_il = 1'b1; o_ps = PS_INC;
        end
        ST_EXEC: begin
          o_fs = w_fs; o_sl = w_sl; o_c0 = w_c0; o_instr_done = 1'b1;
          case (w_grp)
            GRP_ALU_R: begin o_rw = 1'b1; o_da = w_da; o_sa = w_sa; o_sb = w_sb; end
            GRP_ALU_I: begin o_rw = 1'b1; o_da = w_da; o_sa = w_sa; o_k_sel = 1'b1; o_k = w_k_exec; end
            GRP_MOVZ:  begin o_rw = 1'b1; o_da = w_da; o_k_sel = 1'b1; o_k = w_k_exec; end
            GRP_LDUR:  begin
              o_as = 1'b1; o_sa = w_sa; o_k_sel = 1'b1; o_k = w_k_exec; o_instr_done = 1'b0;
            end
            GRP_STUR:  begin
              o_as = 1'b1; o_sa = w_sa; o_sb = w_sb; o_k_sel = 1'b1; o_k = w_k_exec;
              o_ds = DS_B; o_mw = 1'b1;
            end
            GRP_B:     begin o_ps = PS_REL; o_pc_sel = 1'b1; o_k = w_k_exec; end
            GRP_BR:    begin o_ps = PS_ABS; o_sa = w_sa; end
            GRP_CB:    begin o_sa = w_sa; o_instr_done = 1'b0; end
            GRP_BCOND: begin
              o_k = w_k_exec;
              if (cond_true(i_ir[3:0], i_sf)) begin o_ps = PS_REL; o_pc_sel = 1'b1; end
            end
            GRP_HALT:  o_instr_done = 1'b0;
            GRP_ILL:   o_instr_done = !ILLEGAL_HALT;
            default:   ;
          endcase
        end
        // Second cycle of a load repeats the address and writes memory data back
        ST_MEM: begin
          o_as = 1'b1; o_sa = w_sa; o_k_sel = 1'b1; o_k = w_k_exec; o_fs = FS_ADD;
          o_ds = DS_MEM; o_rw = 1'b1; o_da = w_da; o_instr_done = 1'b1;
        end
        // Z now reflects the register passed through in EXEC
        ST_BRCHK: begin
          o_k = w_k_br19; o_instr_done = 1'b1;
          if (w_cbnz ? !i_sf[FLAG_Z] : i_sf[FLAG_Z]) begin o_ps = PS_REL; o_pc_sel = 1'b1; end
        end
        ST_HALT: o_halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
